// File: rtl/sv_mm_if.sv
// Operand/result handshake bundle for the sv_mm modular multiplier.
// Operands move on start_i/ready_o; the result moves on valid_o/res_ready_i.
interface sv_mm_if #(
    parameter int DATA_WIDTH = 128
);
    logic                  start_i;
    logic                  ready_o;
    logic [DATA_WIDTH-1:0] q_i;
    logic [DATA_WIDTH-1:0] a_i;
    logic [DATA_WIDTH-1:0] b_i;
    logic [DATA_WIDTH-1:0] res_o;
    logic                  valid_o;
    logic                  res_ready_i;

    modport master (
        output start_i, q_i, a_i, b_i, res_ready_i,
        input  ready_o, res_o, valid_o
    );

    modport slave (
        input  start_i, q_i, a_i, b_i, res_ready_i,
        output ready_o, res_o, valid_o
    );
endinterface

// File: rtl/sv_mm.sv
// Sequential MSB-first shift-add modular multiplier: res = (a * b) mod q,
// one multiplier bit per clock, fixed DATA_WIDTH-cycle latency.
module sv_mm #(
    parameter int DATA_WIDTH = 128
) (
    input  logic       clk_i,
    input  logic       rst_i,
    sv_mm_if.slave     bus,
    output logic [1:0] state_o
);
    // Handshakes: operands transfer on an edge where start_i && ready_o;
    // the result transfers on an edge where valid_o && res_ready_i, and
    // valid_o/res_o hold stable until then. start_i outside IDLE is ignored.
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                state, state_nx;
    logic [DATA_WIDTH-1:0] q_r, a_r, b_r, acc, res_r;
    logic [CW-1:0]         cnt;
    logic                  valid_r;
    logic                  accept, last, res_take;
    logic [DATA_WIDTH:0]   t1_raw, t1, t2_raw, t2, q_ext, a_add;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        last     = 1'b0;
        res_take = 1'b0;
        case (state)
            IDLE: if (bus.start_i) begin
                accept   = 1'b1;
                state_nx = CALC;
            end
            CALC: if (cnt == '0) begin
                last     = 1'b1;
                state_nx = DONE;
            end
            DONE: if (bus.res_ready_i) begin
                res_take = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // One extra bit keeps 2*acc and t1+a exact even when q is all ones.
    always_comb begin
        q_ext  = {1'b0, q_r};
        a_add  = b_r[cnt] ? {1'b0, a_r} : '0;
        t1_raw = {acc, 1'b0};
        t1     = (t1_raw >= q_ext) ? t1_raw - q_ext : t1_raw;
        t2_raw = t1 + a_add;
        t2     = (t2_raw >= q_ext) ? t2_raw - q_ext : t2_raw;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_r     <= '0;
            a_r     <= '0;
            b_r     <= '0;
            acc     <= '0;
            cnt     <= '0;
            res_r   <= '0;
            valid_r <= 1'b0;
        end else if (accept) begin
            q_r <= bus.q_i;
            a_r <= bus.a_i;
            b_r <= bus.b_i;
            acc <= '0;
            cnt <= CW'(DATA_WIDTH - 1);
        end else if (state == CALC) begin
            acc <= t2[DATA_WIDTH-1:0];
            if (last) begin
                res_r   <= t2[DATA_WIDTH-1:0];
                valid_r <= 1'b1;
            end else begin
                cnt <= cnt - CW'(1);
            end
        end else if (res_take) begin
            valid_r <= 1'b0;
        end
    end

    assign bus.ready_o = (state == IDLE);
    assign bus.valid_o = valid_r;
    assign bus.res_o   = res_r;
    assign state_o     = state;
endmodule
